// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side and ALU-side signals of the shared Power ALU arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the ALU.
interface alu_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned OPW  = 4
);
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  req_a;
    logic [NREQ*DW-1:0]  req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic [NREQ-1:0]     req_acc;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rsp_done;
    logic [DW-1:0]       rsp_result;
    logic                rsp_err;
    logic [DW-1:0]       alu_a;
    logic [DW-1:0]       alu_b;
    logic [OPW-1:0]      alu_op;
    logic                alu_acc;
    logic                alu_en;
    logic                alu_done;
    logic [DW-1:0]       alu_result;

    modport slave (
        input  req, req_a, req_b, req_op, req_acc, alu_done, alu_result,
        output gnt, rsp_done, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_acc, alu_en
    );

    modport master (
        output req, req_a, req_b, req_op, req_acc, alu_done, alu_result,
        input  gnt, rsp_done, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_acc, alu_en
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one Power ALU between NREQ requesters.
// One operation in flight: IDLE -> ISSUE (alu_en pulse) -> WAIT (alu_done) -> RESP (rsp_done pulse).
// Optional macro ALU_TIMEOUT_EN adds a WAIT watchdog that completes with rsp_err after TIMEOUT cycles.
module alu_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned OPW     = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [DW-1:0]   res_q, res_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [OPW-1:0]  op_q, op_d;
    logic            acc_q, acc_d;
    logic            en_q, en_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;

`ifdef ALU_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`else
    // TIMEOUT only matters when the WAIT watchdog is built in
    localparam int unsigned timeout_unused = TIMEOUT;
`endif

    // Round-robin pick: first set req bit at or above ptr, wrapping to 0
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(ptr_q) + k) % NREQ);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        en_d    = 1'b0;
`ifdef ALU_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    a_d     = bus.req_a[32'(pick_idx)*DW +: DW];
                    b_d     = bus.req_b[32'(pick_idx)*DW +: DW];
                    op_d    = bus.req_op[32'(pick_idx)*OPW +: OPW];
                    acc_d   = bus.req_acc[pick_idx];
                    en_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef ALU_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_done) begin
                    res_d   = bus.alu_result;
                    done_d  = gnt_q;
`ifdef ALU_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef ALU_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d   = tmo_q + TW'(1);
                end
`endif
            end
            S_RESP: begin
                gnt_d   = '0;
                ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, synchronous reset discards any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            en_q    <= en_d;
        end
    end

`ifdef ALU_TIMEOUT_EN
    // WAIT watchdog counter and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.gnt        = gnt_q;
    assign bus.rsp_done   = done_q;
    assign bus.rsp_result = res_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_acc    = acc_q;
    assign bus.alu_en     = en_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a scoreboard for alu_arbiter.
// The ALU model returns a+b two cycles after alu_en; a monitor checks every issue and response.
module tb_alu_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned OPW     = 4;
    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) bus ();

    alu_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       acc;
    } issue_t;

    typedef struct {
        int         idx;
        logic [7:0] res;
        logic       err;
    } rsp_t;

    issue_t issue_q[$];
    rsp_t   rsp_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   alu_hang = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic exp_issue(input int idx, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] op, input logic acc);
        issue_t e;
        e.idx = idx; e.a = a; e.b = b; e.op = op; e.acc = acc;
        issue_q.push_back(e);
    endtask

    task automatic exp_rsp(input int idx, input logic [7:0] res, input logic err);
        rsp_t e;
        e.idx = idx; e.res = res; e.err = err;
        rsp_q.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input logic acc);
        bus.req_a[i*DW +: DW]   = a;
        bus.req_b[i*DW +: DW]   = b;
        bus.req_op[i*OPW +: OPW] = op;
        bus.req_acc[i]          = acc;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.rsp_done != '0) begin
                n = k;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no rsp_done within 40 cycles");
        end
    endtask

    task automatic wait_en();
        int seen;
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.alu_en) begin
                seen = 1;
                break;
            end
        end
        if (seen == 0) begin
            checks++;
            errors++;
            $display("FAIL en_timeout: no alu_en within 20 cycles");
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
    endtask

    // ALU model: a+b presented with alu_done two cycles after alu_en
    initial begin : alu_model
        int         cnt;
        logic [7:0] sum;
        cnt = 0;
        sum = '0;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge clk);
            bus.alu_done = 1'b0;
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.alu_done   = 1'b1;
                    bus.alu_result = sum;
                end
            end
            if (bus.alu_en && !alu_hang) begin
                cnt = 2;
                sum = 8'(bus.alu_a + bus.alu_b);
            end
        end
    end

    // Monitor: compares every issue and every response with the scoreboard
    initial begin : monitor
        issue_t ie;
        rsp_t   re;
        forever begin
            @(negedge clk);
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            if (bus.alu_en) begin
                if (issue_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: gnt 0x%0h with nothing expected", bus.gnt);
                end else begin
                    ie = issue_q.pop_front();
                    chk("issue_gnt", 32'(bus.gnt), 32'(1) << ie.idx);
                    chk("issue_a",   32'(bus.alu_a), 32'(ie.a));
                    chk("issue_b",   32'(bus.alu_b), 32'(ie.b));
                    chk("issue_op",  32'(bus.alu_op), 32'(ie.op));
                    chk("issue_acc", 32'(bus.alu_acc), 32'(ie.acc));
                end
            end
            if (bus.rsp_done != '0) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_done 0x%0h with nothing expected", bus.rsp_done);
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_done",   32'(bus.rsp_done), 32'(1) << re.idx);
                    chk("rsp_gnt",    32'(bus.gnt), 32'(1) << re.idx);
                    chk("rsp_result", 32'(bus.rsp_result), 32'(re.res));
                    chk("rsp_err",    32'(bus.rsp_err), 32'(re.err));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Directed stimulus
    initial begin : stim
        int n;
        rst         = 1'b1;
        bus.req     = '0;
        bus.req_a   = '0;
        bus.req_b   = '0;
        bus.req_op  = '0;
        bus.req_acc = '0;
        repeat (3) @(negedge clk);

        chk("rst_gnt",        32'(bus.gnt), 32'd0);
        chk("rst_rsp_done",   32'(bus.rsp_done), 32'd0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_rsp_err",    32'(bus.rsp_err), 32'd0);
        chk("rst_alu_a",      32'(bus.alu_a), 32'd0);
        chk("rst_alu_b",      32'(bus.alu_b), 32'd0);
        chk("rst_alu_op",     32'(bus.alu_op), 32'd0);
        chk("rst_alu_acc",    32'(bus.alu_acc), 32'd0);
        chk("rst_alu_en",     32'(bus.alu_en), 32'd0);
        rst = 1'b0;

        // Single op from requester 0: latency and result
        set_op(0, 8'h12, 8'h34, 4'h0, 1'b0);
        exp_issue(0, 8'h12, 8'h34, 4'h0, 1'b0);
        exp_rsp(0, 8'h46, 1'b0);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("t1_en_latency", 32'(bus.alu_en), 32'd1);
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        wait_rsp(n);
        chk("t1_rsp_latency", 32'(n), 32'd3);
        bus.req = '0;
        @(negedge clk);
        chk("t1_gnt_clear", 32'(bus.gnt), 32'd0);
        chk("t1_done_clear", 32'(bus.rsp_done), 32'd0);

        // All four held: order 0,1,2,3,0
        reset_dut();
        for (int i = 0; i < 4; i++)
            set_op(i, 8'(8'h11 * (i + 1)), 8'(i + 1), 4'(i + 8), 1'(i));
        for (int k = 0; k < 5; k++) begin
            exp_issue(k % 4, 8'(8'h11 * ((k % 4) + 1)), 8'((k % 4) + 1), 4'((k % 4) + 8), 1'(k % 4));
            exp_rsp(k % 4, 8'(8'h11 * ((k % 4) + 1) + (k % 4) + 1), 1'b0);
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_rsp(n);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // req0 held, req2 raised once during op 0: order 0,2,0
        reset_dut();
        set_op(0, 8'h20, 8'h01, 4'h1, 1'b1);
        set_op(2, 8'h30, 8'h02, 4'h2, 1'b0);
        exp_issue(0, 8'h20, 8'h01, 4'h1, 1'b1); exp_rsp(0, 8'h21, 1'b0);
        exp_issue(2, 8'h30, 8'h02, 4'h2, 1'b0); exp_rsp(2, 8'h32, 1'b0);
        exp_issue(0, 8'h20, 8'h01, 4'h1, 1'b1); exp_rsp(0, 8'h21, 1'b0);
        bus.req = 4'b0001;
        wait_en();
        bus.req = 4'b0101;
        wait_rsp(n);
        wait_rsp(n);
        bus.req = 4'b0001;
        wait_rsp(n);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Operand change during WAIT is ignored
        reset_dut();
        set_op(1, 8'h05, 8'h11, 4'h3, 1'b0);
        exp_issue(1, 8'h05, 8'h11, 4'h3, 1'b0);
        exp_rsp(1, 8'h16, 1'b0);
        bus.req = 4'b0010;
        wait_en();
        @(negedge clk);
        bus.req_a[1*DW +: DW] = 8'hFF;
        @(negedge clk);
        chk("t4_alu_a_hold", 32'(bus.alu_a), 32'h05);
        wait_rsp(n);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Reset during WAIT of requester 3: op discarded, stale alu_done ignored
        reset_dut();
        set_op(3, 8'h40, 8'h04, 4'h0, 1'b0);
        exp_issue(3, 8'h40, 8'h04, 4'h0, 1'b0);
        bus.req = 4'b1000;
        wait_en();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_gnt",        32'(bus.gnt), 32'd0);
        chk("t5_rsp_done",   32'(bus.rsp_done), 32'd0);
        chk("t5_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("t5_alu_a",      32'(bus.alu_a), 32'd0);
        chk("t5_alu_b",      32'(bus.alu_b), 32'd0);
        chk("t5_alu_en",     32'(bus.alu_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_done", 32'(bus.rsp_done), 32'd0);
            chk("t5_no_gnt",  32'(bus.gnt), 32'd0);
        end
        set_op(0, 8'h0A, 8'h0B, 4'h5, 1'b1);
        exp_issue(0, 8'h0A, 8'h0B, 4'h5, 1'b1);
        exp_rsp(0, 8'h15, 1'b0);
        bus.req = 4'b1001;
        wait_rsp(n);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // ALU never completes
        reset_dut();
        alu_hang = 1'b1;
        set_op(2, 8'h55, 8'h66, 4'h7, 1'b0);
        exp_issue(2, 8'h55, 8'h66, 4'h7, 1'b0);
`ifdef ALU_TIMEOUT_EN
        exp_rsp(2, 8'h00, 1'b1);
        bus.req = 4'b0100;
        wait_en();
        wait_rsp(n);
        chk("t6_timeout_latency", 32'(n), 32'd9);
        bus.req = '0;
        repeat (3) @(negedge clk);
`else
        bus.req = 4'b0100;
        wait_en();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t6_gnt_held", 32'(bus.gnt), 32'h4);
            chk("t6_no_done",  32'(bus.rsp_done), 32'd0);
        end
        reset_dut();
`endif
        alu_hang = 1'b0;

        repeat (5) @(negedge clk);
        chk("issue_q_empty", 32'(issue_q.size()), 32'd0);
        chk("rsp_q_empty",   32'(rsp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
